// File: rtl/pc_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_if : fetch-PC controller bus (hazard/D/CP0 inputs, IM-side outs)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface pc_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              imem_ready;
    logic [ADDR_W-1:0] pc_d4;
    logic [25:0]       imm_index;
    logic [ADDR_W-1:0] reg_target;
    logic              cmp;
    logic              is_b;
    logic              is_j;
    logic              is_jr;
    logic              exc_req;
    logic              eret;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] pc_f4;
    logic              fetch_kill;
    logic              adel_f;
    logic              pend_vld;

    modport master (
        output stall, imem_ready, pc_d4, imm_index, reg_target, cmp,
               is_b, is_j, is_jr, exc_req, eret, epc,
        input  pc_f, pc_f4, fetch_kill, adel_f, pend_vld
    );

    modport slave (
        input  stall, imem_ready, pc_d4, imm_index, reg_target, cmp,
               is_b, is_j, is_jr, exc_req, eret, epc,
        output pc_f, pc_f4, fetch_kill, adel_f, pend_vld
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_fetch_ctrl : registered fetch PC with next-PC select and redirect buffer|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pc_fetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [ADDR_W-1:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] TEXT_HI  = 32'h0000_6ffc
) (
    input  wire logic   clk,
    input  wire logic   reset,
    pc_fetch_if.slave   bus
);
    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_j_tgt;
    logic [ADDR_W-1:0] w_hard_tgt;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_hard;
    logic              w_soft;
    logic              w_redirect;
    logic              w_pend;

    assign w_pend   = (state_q == c_ST_WAIT);
    assign w_br_tgt = bus.pc_d4 + {{(ADDR_W-18){bus.imm_index[15]}}, bus.imm_index[15:0], 2'b00};
    assign w_j_tgt  = {bus.pc_d4[ADDR_W-1:28], bus.imm_index, 2'b00};

    assign w_hard     = bus.exc_req | bus.eret;
    assign w_hard_tgt = bus.exc_req ? EXC_VEC : bus.epc;
    // Soft redirects are ignored while stalled or while one is already buffered.
    assign w_soft     = ~bus.stall & ~w_pend & (bus.is_jr | bus.is_j | (bus.is_b & bus.cmp));
    assign w_redirect = w_hard | w_soft;

    always_comb begin
        w_tgt = w_br_tgt;
        if (w_hard)
            w_tgt = w_hard_tgt;
        else if (bus.is_jr)
            w_tgt = bus.reg_target;
        else if (bus.is_j)
            w_tgt = w_j_tgt;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            c_ST_RUN: begin
                if (!w_redirect) begin
                    if (bus.imem_ready && !bus.stall)
                        pc_d = pc_q + ADDR_W'(4);
                end else if (bus.imem_ready) begin
                    pc_d = w_tgt;
                end else begin
                    pend_pc_d = w_tgt;
                    state_d   = c_ST_WAIT;
                end
            end
            default: begin
                if (bus.imem_ready) begin
                    pc_d    = w_hard ? w_hard_tgt : pend_pc_q;
                    state_d = c_ST_RUN;
                end else if (w_hard) begin
                    pend_pc_d = w_hard_tgt;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= c_ST_RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign bus.pc_f       = pc_q;
    assign bus.pc_f4      = pc_q + ADDR_W'(4);
    assign bus.pend_vld   = w_pend;
    assign bus.fetch_kill = reset & bus.imem_ready & (w_pend | w_hard);
    assign bus.adel_f     = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_fetch_ctrl : directed and randomized bench with a behavioural model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_ctrl;
    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] c_EXC_VEC  = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    pc_fetch_if #(.ADDR_W(32)) bus();

    pc_fetch_ctrl #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural PC plus a queue holding at most one buffered redirect.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    function automatic bit m_adel(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
    endfunction

    function automatic bit m_kill();
        return reset && bus.imem_ready && (m_pend.size() != 0 || bus.exc_req || bus.eret);
    endfunction

    task automatic model_step();
        logic [31:0] tgt;
        logic [31:0] off;
        bit          have;
        if (!reset) begin
            m_pc = c_RESET_PC;
            m_pend.delete();
            return;
        end
        have = 1'b1;
        off  = 32'(signed'(bus.imm_index[15:0])) * 4;
        if (bus.exc_req)      tgt = c_EXC_VEC;
        else if (bus.eret)    tgt = bus.epc;
        else if (bus.stall || m_pend.size() != 0) have = 1'b0;
        else if (bus.is_jr)   tgt = bus.reg_target;
        else if (bus.is_j)    tgt = (bus.pc_d4 & 32'hf000_0000) | (32'(bus.imm_index) * 4);
        else if (bus.is_b && bus.cmp) tgt = bus.pc_d4 + off;
        else have = 1'b0;
        if (m_pend.size() != 0) begin
            if (bus.imem_ready) begin
                m_pc = (bus.exc_req || bus.eret) ? tgt : m_pend[0];
                m_pend.delete();
            end else if (bus.exc_req || bus.eret) begin
                m_pend[0] = tgt;
            end
        end else if (!have) begin
            if (bus.imem_ready && !bus.stall) m_pc = m_pc + 4;
        end else if (bus.imem_ready) begin
            m_pc = tgt;
        end else begin
            m_pend.push_back(tgt);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.imem_ready = 0; bus.pc_d4 = 0; bus.imm_index = 0;
        bus.reg_target = 0; bus.cmp = 0; bus.is_b = 0; bus.is_j = 0; bus.is_jr = 0;
        bus.exc_req = 0; bus.eret = 0; bus.epc = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        bus.imem_ready = 1; bus.exc_req = 1;
        #1;
        n_cmp++;
        if (bus.fetch_kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill got %b want 0", bus.fetch_kill); end
        tick(); tick();
        n_cmp++;
        if (bus.pc_f !== c_RESET_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc_f, c_RESET_PC); end
        n_cmp++;
        if (bus.pend_vld !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b want 0", bus.pend_vld); end
        clear_inputs();
        reset = 1;
    endtask

    task automatic test_sequential();
        do_reset();
        bus.imem_ready = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (bus.pc_f !== 32'h3000 + 32'(4 * i)) begin
                n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc_f, 32'h3000 + 32'(4 * i));
            end
        end
        do_reset();
        bus.imem_ready = 1; bus.stall = 1;
        repeat (3) tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3000) begin n_fail++; $display("FAIL stall_hold got %h want 3000", bus.pc_f); end
    endtask

    task automatic test_branch();
        logic [31:0] prev;
        do_reset();
        bus.imem_ready = 1; bus.is_b = 1; bus.cmp = 1; bus.pc_d4 = 32'h3008; bus.imm_index = 26'h000fffe;
        #1;
        n_cmp++;
        if (bus.fetch_kill !== 1'b0) begin n_fail++; $display("FAIL br_kill got %b want 0", bus.fetch_kill); end
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3000) begin n_fail++; $display("FAIL br_taken got %h want 3000", bus.pc_f); end
        bus.cmp = 0;
        prev = bus.pc_f;
        tick();
        n_cmp++;
        if (bus.pc_f !== prev + 4) begin n_fail++; $display("FAIL br_not_taken got %h want %h", bus.pc_f, prev + 4); end
        clear_inputs();
    endtask

    task automatic test_jump();
        do_reset();
        bus.imem_ready = 1; bus.is_j = 1; bus.imm_index = 26'h0000c01; bus.pc_d4 = 32'h3010;
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3004) begin n_fail++; $display("FAIL j_target got %h want 3004", bus.pc_f); end
        bus.is_j = 0; bus.is_jr = 1; bus.reg_target = 32'h3011;
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3011) begin n_fail++; $display("FAIL jr_target got %h want 3011", bus.pc_f); end
        n_cmp++;
        if (bus.adel_f !== 1'b1) begin n_fail++; $display("FAIL jr_adel got %b want 1", bus.adel_f); end
        n_cmp++;
        if (bus.pc_f4 !== 32'h3015) begin n_fail++; $display("FAIL jr_pc4 got %h want 3015", bus.pc_f4); end
        clear_inputs();
    endtask

    task automatic test_buffered();
        do_reset();
        bus.is_jr = 1; bus.reg_target = 32'h3400;
        tick();
        n_cmp++;
        if (bus.pend_vld !== 1'b1) begin n_fail++; $display("FAIL buf_pend got %b want 1", bus.pend_vld); end
        n_cmp++;
        if (bus.pc_f !== 32'h3000) begin n_fail++; $display("FAIL buf_hold got %h want 3000", bus.pc_f); end
        bus.is_jr = 0; bus.imem_ready = 1;
        #1;
        n_cmp++;
        if (bus.fetch_kill !== 1'b1) begin n_fail++; $display("FAIL buf_kill got %b want 1", bus.fetch_kill); end
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3400) begin n_fail++; $display("FAIL buf_pc got %h want 3400", bus.pc_f); end
        n_cmp++;
        if (bus.pend_vld !== 1'b0) begin n_fail++; $display("FAIL buf_clear got %b want 0", bus.pend_vld); end
        clear_inputs();
    endtask

    task automatic test_hard_in_wait();
        do_reset();
        bus.is_jr = 1; bus.reg_target = 32'h3400;
        tick();
        bus.is_jr = 0; bus.exc_req = 1;
        tick();
        bus.exc_req = 0;
        tick();
        n_cmp++;
        if (bus.pend_vld !== 1'b1 || bus.pc_f !== 32'h3000) begin
            n_fail++; $display("FAIL hw_wait got pend=%b pc=%h want pend=1 pc=3000", bus.pend_vld, bus.pc_f);
        end
        bus.imem_ready = 1;
        tick();
        n_cmp++;
        if (bus.pc_f !== c_EXC_VEC) begin n_fail++; $display("FAIL hw_exc_pc got %h want 4180", bus.pc_f); end
        bus.eret = 1; bus.epc = 32'h3020; bus.exc_req = 1;
        #1;
        n_cmp++;
        if (bus.fetch_kill !== 1'b1) begin n_fail++; $display("FAIL hw_kill got %b want 1", bus.fetch_kill); end
        tick();
        n_cmp++;
        if (bus.pc_f !== c_EXC_VEC) begin n_fail++; $display("FAIL exc_over_eret got %h want 4180", bus.pc_f); end
        bus.exc_req = 0;
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3020) begin n_fail++; $display("FAIL eret_pc got %h want 3020", bus.pc_f); end
        clear_inputs();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        bus.is_jr = 1; bus.reg_target = 32'h3400;
        tick();
        bus.is_jr = 0; bus.imem_ready = 1; reset = 0;
        #1;
        n_cmp++;
        if (bus.fetch_kill !== 1'b0) begin n_fail++; $display("FAIL rw_kill got %b want 0", bus.fetch_kill); end
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3000 || bus.pend_vld !== 1'b0) begin
            n_fail++; $display("FAIL rw_state got pc=%h pend=%b want pc=3000 pend=0", bus.pc_f, bus.pend_vld);
        end
        reset = 1;
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h3004) begin n_fail++; $display("FAIL rw_discard got %h want 3004", bus.pc_f); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.imem_ready = 1; bus.is_jr = 1; bus.reg_target = 32'hffff_fffc;
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'hffff_fffc) begin n_fail++; $display("FAIL wrap_pc got %h want fffffffc", bus.pc_f); end
        n_cmp++;
        if (bus.pc_f4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h want 0", bus.pc_f4); end
        n_cmp++;
        if (bus.adel_f !== 1'b1) begin n_fail++; $display("FAIL wrap_adel got %b want 1", bus.adel_f); end
        bus.is_jr = 0;
        tick();
        n_cmp++;
        if (bus.pc_f !== 32'h0 || bus.adel_f !== 1'b1) begin
            n_fail++; $display("FAIL wrap_next got pc=%h adel=%b want pc=0 adel=1", bus.pc_f, bus.adel_f);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 99) != 0);
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.imem_ready = ($urandom_range(0, 2) != 0);
            bus.pc_d4      = 32'h3000 + 32'($urandom_range(0, 32'hfff)) * 4;
            bus.imm_index  = 26'($urandom);
            bus.reg_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 32'($urandom_range(0, 32'hfff)) * 4;
            bus.cmp        = 1'($urandom);
            bus.is_b       = ($urandom_range(0, 5) == 0);
            bus.is_j       = ($urandom_range(0, 7) == 0);
            bus.is_jr      = ($urandom_range(0, 7) == 0);
            bus.exc_req    = ($urandom_range(0, 15) == 0);
            bus.eret       = ($urandom_range(0, 15) == 0);
            bus.epc        = 32'h3000 + 32'($urandom_range(0, 32'hfff)) * 4;
            #1;
            n_cmp++;
            if (bus.fetch_kill !== m_kill() || bus.pend_vld !== (m_pend.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_comb[%0d] got kill=%b pend=%b want kill=%b pend=%b",
                         i, bus.fetch_kill, bus.pend_vld, m_kill(), m_pend.size() != 0);
            end
            tick();
            n_cmp++;
            if (bus.pc_f !== m_pc || bus.pc_f4 !== m_pc + 4 || bus.adel_f !== m_adel(m_pc)) begin
                n_fail++;
                $display("FAIL rnd_pc[%0d] got pc=%h pc4=%h adel=%b want pc=%h pc4=%h adel=%b",
                         i, bus.pc_f, bus.pc_f4, bus.adel_f, m_pc, m_pc + 4, m_adel(m_pc));
            end
        end
        reset = 1;
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_buffered();
        test_hard_in_wait();
        test_reset_in_wait();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
